serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor with word framing, LSB first, two's complement.
- Adds an internal recirculating delay line so results can feed back as an accumulator.
- Generalises the plain serial adder: configurable word length, four operation modes, framed carry handling and overflow detection.
- Sits in the arithmetic unit between the store/serial data paths and the accumulator logic.

Parameters:
- WORD_LEN, 17, digits per word; must be at least 2.
- CNT_W, $clog2(WORD_LEN+1), width of the internal digit counter; derived, do not override.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- word_start  input  1  high in the cycle carrying digit 0 (LSB) of a new word
- op  input  2  operation; sampled only when word_start=1. 00 ADD a+b; 01 SUB a-b; 10 ACC_ADD line+a; 11 ACC_SUB line-a
- a  input  1  serial operand A digit
- b  input  1  serial operand B digit; ignored in ACC modes
- sum  output  1  registered serial result digit
- word_done  output  1  one-cycle pulse coincident with the result MSB on sum
- ovf  output  1  one-cycle pulse with word_done when signed overflow occurred
- acc_valid  output  1  delay line holds a complete, aligned previous result

Behaviour:
- Reset (async, rst=1): counter to IDLE, carry=0, op register=00, sum=0, word_done=0, ovf=0, delay line all 0, acc_valid=0.
- Digit counter:
  - word_start=1 loads digit index 0 and latches op.
  - Otherwise, while index < WORD_LEN-1, it increments each cycle.
  - After digit WORD_LEN-1 it goes to IDLE.
  - IDLE: no shifting; sum=0, word_done=0, ovf=0; a and b ignored.
- Operand selection:
  - ADD: x=a, y=b.
  - SUB: x=a, y=~b.
  - ACC_ADD: x=line_tail, y=a.
  - ACC_SUB: x=line_tail, y=~a.
  - In ACC modes with acc_valid=0, line_tail is forced to 0.
- Carry-in at digit 0 is 1 for SUB and ACC_SUB, otherwise 0. On later digits it is the stored carry.
- Combinational digit: s = x^y^cin; cout = majority(x,y,cin). cout is registered into carry each active cycle.
- Latency: sum registers s. The result digit appears one cycle after the input digit, so a word of WORD_LEN inputs yields WORD_LEN contiguous sum digits.
- Delay line:
  - WORD_LEN-bit shift register; shifts in s only on active cycles.
  - line_tail is the same digit of the previous word, regardless of idle gaps between words.
- Overflow and word end:
  - At digit WORD_LEN-1: ovf_next = cin ^ cout (carry into MSB XOR carry out of MSB).
  - word_done and ovf register alongside sum.
  - Carry is ignored across words; each word re-initialises it.
  - acc_valid is set when word_done is registered.
- Back-to-back words: word_start in the cycle after digit WORD_LEN-1 is legal and loses no cycle.
- Abort: word_start while the counter is active and not IDLE:
  - Restarts at digit 0 with the new op.
  - No word_done or ovf for the aborted word.
  - acc_valid clears in the same edge, because the delay line is now misaligned. It re-sets only after the next completed word.
- Reset mid-word: every register returns to its reset value immediately. No partial word_done.
- op changes mid-word have no effect.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_STICKY_EN.
- When defined:
  - Adds output port ovf_sticky (1 bit), set on any ovf pulse.
  - Cleared only by rst, or by word_start with op=10 while acc_valid=0 (a fresh accumulation chain).
  - ovf pulse behaviour is unchanged.
- When not defined: the port and its logic are absent.

Test Plan (WORD_LEN=8):
- ADD 5+3: a=0x05, b=0x03, word_start at digit 0 -> sum digits LSB first 0,0,0,1,0,0,0,0 (0x08), starting one cycle later; word_done on the 8th; ovf=0.
- SUB 3-5: a=0x03, b=0x05 -> sum=0xFE; ovf=0.
- Overflow: ADD 0x7F+0x01 -> sum=0x80, word_done=1 and ovf=1 in the same cycle. SUB 0x80-0x01 -> sum=0x7F, ovf=1.
- Accumulate with gaps: ACC_ADD words a=10, 20, 30, with 3 idle cycles between words:
  - results 10, 30, 60;
  - acc_valid=0 before the first word_done and 1 after;
  - a following ACC_SUB a=60 -> 0.
- Abort: word_start again at digit 4 of an ADD -> no word_done for the first word; acc_valid drops; the second word ADD 0x12+0x21 -> 0x33 with correct timing; ACC_ADD then uses line_tail=0.
- Async reset: assert rst mid-word between clock edges -> sum, word_done, ovf and acc_valid go 0 immediately; after release, the next word is correct. With the macro defined, ovf_sticky is held through non-overflowing words and cleared by rst.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial two's complement add/sub with word framing and a recirculating delay line.
// Optional SERIAL_ADDSUB_OVF_STICKY_EN adds a sticky overflow flag output.
module serial_addsub #(
  parameter int WORD_LEN = 17,
  parameter int CNT_W    = $clog2(WORD_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       word_start,
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       sum,
  output logic       word_done,
  output logic       ovf,
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
  output logic       ovf_sticky,
`endif
  output logic       acc_valid
);

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    SUB     = 2'b01,
    ACC_ADD = 2'b10,
    ACC_SUB = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_LEN - 1);
  localparam logic [CNT_W-1:0] IDLE = CNT_W'(WORD_LEN);

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    idx;
  op_t                 op_q;
  op_t                 op_c;
  logic                carry;
  logic [WORD_LEN-1:0] line;
  logic                active;
  logic                abort;
  logic                last;
  logic                tail;
  logic                x;
  logic                y;
  logic                cin;
  logic                s;
  logic                cout;

  always_comb begin
    active = word_start | (cnt != IDLE);
    abort  = word_start & (cnt != IDLE);
    idx    = word_start ? '0 : cnt;
    op_c   = word_start ? op_t'(op) : op_q;
    last   = active & (idx == LAST);
    // an aborting word must not see the now-misaligned line
    tail   = line[WORD_LEN-1] & acc_valid & ~abort;
    x      = a;
    y      = b;
    unique case (op_c)
      ADD:     begin x = a;    y = b;  end
      SUB:     begin x = a;    y = ~b; end
      ACC_ADD: begin x = tail; y = a;  end
      ACC_SUB: begin x = tail; y = ~a; end
      default: begin x = a;    y = b;  end
    endcase
    cin  = word_start ? op_c[0] : carry;
    s    = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= IDLE;
      op_q       <= ADD;
      carry      <= 1'b0;
      line       <= '0;
      sum        <= 1'b0;
      word_done  <= 1'b0;
      ovf        <= 1'b0;
      acc_valid  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
      ovf_sticky <= 1'b0;
`endif
    end else begin
      if (word_start)
        op_q <= op_t'(op);
      if (active) begin
        cnt   <= last ? IDLE : idx + CNT_W'(1);
        carry <= cout;
        line  <= {line[WORD_LEN-2:0], s};
      end
      sum       <= active & s;
      word_done <= last;
      ovf       <= last & (cin ^ cout);
      if (abort)
        acc_valid <= 1'b0;
      else if (last)
        acc_valid <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
      if (word_start && op == 2'b10 && !acc_valid)
        ovf_sticky <= 1'b0;
      else if (last && (cin ^ cout))
        ovf_sticky <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WORD_LEN=8): directed plan steps plus random words
// checked against an integer-arithmetic word model.
module tb_serial_addsub;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       word_start;
  logic [1:0] op;
  logic       a;
  logic       b;
  logic       sum;
  logic       word_done;
  logic       ovf;
  logic       acc_valid;
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
  logic       ovf_sticky;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] prev;
  bit prev_v;
  logic av0;

  serial_addsub #(.WORD_LEN(W)) dut (
    .clk(clk),
    .rst(rst),
    .word_start(word_start),
    .op(op),
    .a(a),
    .b(b),
    .sum(sum),
    .word_done(word_done),
    .ovf(ovf),
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
    .ovf_sticky(ovf_sticky),
`endif
    .acc_valid(acc_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word-level reference: signed integer arithmetic on whole words.
  function automatic void model(input logic [1:0] o, input logic [7:0] av,
                                input logic [7:0] bv, output logic [7:0] r,
                                output logic v);
    int x;
    int y;
    int t;
    if (o[1]) begin
      x = prev_v ? int'($signed(prev)) : 0;
      y = int'($signed(av));
    end else begin
      x = int'($signed(av));
      y = int'($signed(bv));
    end
    t = o[0] ? x - y : x + y;
    r = t[7:0];
    v = (t > 127) || (t < -128);
  endfunction

  task automatic run_word(input logic [1:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input string tag,
                          output logic v0);
    logic [7:0] r;
    logic ov;
    logic [7:0] got;
    logic done_ok;
    logic ov_got;
    model(o, av, bv, r, ov);
    done_ok = 1'b1;
    ov_got = 1'b0;
    v0 = 1'b0;
    for (int i = 0; i < W; i++) begin
      word_start = (i == 0);
      op = (i == 0) ? o : ~o;
      a = av[i];
      b = bv[i];
      @(posedge clk);
      #1;
      got[i] = sum;
      if (i == 0) v0 = acc_valid;
      if (word_done !== (i == W - 1)) done_ok = 1'b0;
      if (i == W - 1) ov_got = ovf;
      else if (ovf !== 1'b0) done_ok = 1'b0;
    end
    word_start = 1'b0;
    a = 1'b0;
    b = 1'b0;
    chk({tag, "_sum"}, 32'(got), 32'(r));
    chk({tag, "_done"}, 32'(done_ok), 32'd1);
    chk({tag, "_ovf"}, 32'(ov_got), 32'(ov));
    chk({tag, "_accv"}, 32'(acc_valid), 32'd1);
    prev = r;
    prev_v = 1'b1;
  endtask

  task automatic partial(input logic [1:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input int k, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < k; i++) begin
      word_start = (i == 0);
      op = o;
      a = av[i];
      b = bv[i];
      @(posedge clk);
      #1;
      if (word_done || ovf) seen = 1'b1;
    end
    chk({tag, "_nodone"}, 32'(seen), 32'd0);
  endtask

  task automatic idle(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    word_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      @(posedge clk);
      #1;
      if (sum || word_done || ovf) seen = 1'b1;
    end
    a = 1'b0;
    b = 1'b0;
    chk({tag, "_idle"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;
    rst = 1'b1;
    word_start = 1'b0;
    op = 2'b00;
    a = 1'b0;
    b = 1'b0;
    prev = '0;
    prev_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'({sum, word_done, ovf, acc_valid}), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_word(2'b00, 8'h05, 8'h03, "add53", av0);
    chk("add53_val", 32'(prev), 32'h08);
    run_word(2'b01, 8'h03, 8'h05, "sub35", av0);
    chk("sub35_val", 32'(prev), 32'hFE);
    run_word(2'b00, 8'h7F, 8'h01, "add_ovf", av0);
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
    chk("sticky_set", 32'(ovf_sticky), 32'd1);
`endif
    run_word(2'b01, 8'h80, 8'h01, "sub_ovf", av0);
    chk("sub_ovf_val", 32'(prev), 32'h7F);
    idle(3, "gap1");
    run_word(2'b00, 8'h05, 8'h03, "add53b", av0);
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
    chk("sticky_hold", 32'(ovf_sticky), 32'd1);
`endif

    // async reset in the middle of an all-ones word
    partial(2'b00, 8'hFF, 8'h00, 3, "pre_rst");
    chk("pre_rst_sum", 32'(sum), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 32'({sum, word_done, ovf, acc_valid}), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_STICKY_EN
    chk("sticky_rst", 32'(ovf_sticky), 32'd0);
`endif
    word_start = 1'b0;
    rst = 1'b0;
    prev = '0;
    prev_v = 1'b0;
    @(posedge clk);
    #1;
    run_word(2'b00, 8'h21, 8'h11, "post_rst", av0);

    // fresh accumulation chain
    rst = 1'b1;
    #2;
    rst = 1'b0;
    prev_v = 1'b0;
    @(posedge clk);
    #1;
    run_word(2'b10, 8'd10, 8'h00, "acc10", av0);
    chk("acc10_v0", 32'(av0), 32'd0);
    idle(3, "gap2");
    run_word(2'b10, 8'd20, 8'h00, "acc20", av0);
    chk("acc20_val", 32'(prev), 32'd30);
    idle(3, "gap3");
    run_word(2'b10, 8'd30, 8'h00, "acc30", av0);
    chk("acc30_val", 32'(prev), 32'd60);
    run_word(2'b11, 8'd60, 8'h00, "accsub60", av0);
    chk("accsub60_val", 32'(prev), 32'd0);

    // abort at digit 4, then restart
    run_word(2'b00, 8'h01, 8'h02, "pre_abort", av0);
    partial(2'b00, 8'h55, 8'h0F, 4, "abort1");
    prev_v = 1'b0;
    run_word(2'b00, 8'h12, 8'h21, "abort_add", av0);
    chk("abort_accv", 32'(av0), 32'd0);
    chk("abort_val", 32'(prev), 32'h33);
    partial(2'b00, 8'hAA, 8'h11, 3, "abort2");
    prev_v = 1'b0;
    run_word(2'b10, 8'h05, 8'h00, "abort_acc", av0);
    chk("abort_acc_v0", 32'(av0), 32'd0);
    chk("abort_acc_val", 32'(prev), 32'h05);
    run_word(2'b10, 8'h07, 8'h00, "b2b_acc", av0);
    chk("b2b_acc_val", 32'(prev), 32'h0C);

    for (int n = 0; n < 30; n++) begin
      ro = 2'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_word(ro, ra, rb, "rnd", av0);
      if ($urandom_range(0, 1) == 1)
        idle($urandom_range(1, 3), "rnd_gap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
